cipher_scheduler: RTL and testbench

Two-channel frame scheduler that time-shares one 8-bit LFSR keystream engine between two byte-stream requesters. It keeps a saved keystream context per channel, so each channel sees an unbroken keystream across frames. It arbitrates round-robin at frame granularity and XORs the granted channel's bytes with the keystream. It sits between the requester ports and the downstream byte sink, and replaces per-channel cipher instances.

---
 rtl/cipher_scheduler_if.sv | 23 ++
 rtl/cipher_scheduler.sv | 156 +++++++++++++++
 tb/tb_cipher_scheduler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_scheduler_if.sv
// Requester-side byte streams and downstream sink bundle for cipher_scheduler.
// slave = scheduler side, master = requester/sink side.
interface cipher_scheduler_if;
    logic [1:0] in_valid;
    logic [7:0] in_data0;
    logic [7:0] in_data1;
    logic [1:0] in_last;
    logic [1:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ch;
    logic       out_last;

    modport slave (
        input  in_valid, in_data0, in_data1, in_last,
        output in_ready, out_valid, out_data, out_ch, out_last
    );

    modport master (
        output in_valid, in_data0, in_data1, in_last,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );
endinterface

// File: rtl/cipher_scheduler.sv
// Two-channel frame scheduler sharing one LFSR keystream with per-channel saved context.
// Optional idle timeout inside a frame: define CIPHER_SCHED_TIMEOUT_EN.
module cipher_scheduler #(
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [7:0] SEED           = 8'hCD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               seed_wr,
    input  logic               seed_ch,
    input  logic [7:0]         seed_data,
    cipher_scheduler_if.slave  bus,
    output logic               abort
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, SAVE} state_t;

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       prio_q;
    logic       dirty_q;
    logic [7:0] lfsr_q;
    logic [7:0] ctx_q [2];
    logic [7:0] lfsr_next;
    logic [7:0] data_sel;
    logic       last_sel;
    logic       accept;
    logic       tmo;

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign data_sel  = grant_q ? bus.in_data1 : bus.in_data0;
    assign last_sel  = bus.in_last[grant_q];
    assign accept    = (state_q == RUN) && bus.in_valid[grant_q] && bus.in_ready[grant_q];

`ifdef CIPHER_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] idle_cnt_q;
    logic          abort_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle of the frame
    assign tmo = (state_q == RUN) && !bus.in_valid[grant_q]
                 && (idle_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            abort_q <= tmo;
            if (state_q != RUN || accept) begin
                idle_cnt_q <= '0;
            end else if (!bus.in_valid[grant_q]) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
        end
    end

    assign abort = abort_q;
`else
    assign tmo   = 1'b0;
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                unique case (bus.in_valid)
                    2'b11: begin
                        grant_d = prio_q;
                        state_d = LOAD;
                    end
                    2'b01: begin
                        grant_d = 1'b0;
                        state_d = LOAD;
                    end
                    2'b10: begin
                        grant_d = 1'b1;
                        state_d = LOAD;
                    end
                    default: ;
                endcase
            end
            LOAD: state_d = RUN;
            RUN: begin
                if ((accept && last_sel) || tmo) begin
                    state_d = SAVE;
                end
            end
            SAVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            prio_q       <= 1'b0;
            dirty_q      <= 1'b0;
            lfsr_q       <= SEED;
            bus.in_ready <= 2'b00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            // Ready follows the upcoming state, so it is high exactly in RUN
            bus.in_ready <= (state_d == RUN) ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
            if (state_q == LOAD) begin
                lfsr_q <= ctx_q[grant_q];
            end else if (accept) begin
                lfsr_q <= lfsr_next;
            end
            if (state_q == SAVE) begin
                prio_q  <= ~grant_q;
                dirty_q <= 1'b0;
            end else if (seed_wr && seed_ch == grant_q
                         && (state_q == LOAD || state_q == RUN)) begin
                dirty_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx_q[0] <= SEED;
            ctx_q[1] <= SEED;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (seed_wr && seed_ch == 1'(i)) begin
                    ctx_q[i] <= seed_data;
                end else if (state_q == SAVE && grant_q == 1'(i) && !dirty_q) begin
                    ctx_q[i] <= lfsr_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= 8'h00;
            bus.out_ch    <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            bus.out_valid <= accept;
            bus.out_last  <= accept && last_sel;
            if (accept) begin
                bus.out_data <= data_sel ^ lfsr_q;
                bus.out_ch   <= grant_q;
            end
        end
    end

endmodule

// File: tb/tb_cipher_scheduler.sv
// Scoreboard bench for cipher_scheduler: directed frames, expected bytes hand-computed.
// Expected outputs are queued at issue time and checked by an independent monitor.
module tb_cipher_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       seed_wr = 1'b0;
    logic       seed_ch = 1'b0;
    logic [7:0] seed_data = 8'h00;
    logic       abort;

    cipher_scheduler_if bus ();

    cipher_scheduler #(
        .TIMEOUT_CYCLES (16),
        .SEED           (8'hCD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_wr   (seed_wr),
        .seed_ch   (seed_ch),
        .seed_data (seed_data),
        .bus       (bus.slave),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       ch;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   abort_seen = 0;
    int   ready_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data %0h ch %0d with empty queue",
                         bus.out_data, bus.out_ch);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", 32'(bus.out_data), 32'(mon_e.data));
                check("out_ch", 32'(bus.out_ch), 32'(mon_e.ch));
                check("out_last", 32'(bus.out_last), 32'(mon_e.last));
            end
        end
        if (abort) abort_seen++;
        if (bus.in_ready == 2'b11) ready_bad++;
    end

    task automatic clear_inputs();
        bus.in_valid = 2'b00;
        bus.in_last  = 2'b00;
        bus.in_data0 = 8'h00;
        bus.in_data1 = 8'h00;
    endtask

    task automatic gap();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic send(input logic ch, input logic [7:0] d, input logic last,
                        input logic [7:0] exp_d);
        int n;
        bus.in_valid[ch] = 1'b1;
        bus.in_last[ch]  = last;
        if (ch) bus.in_data1 = d;
        else    bus.in_data0 = d;
        sb.push_back('{data: exp_d, ch: ch, last: last});
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready[ch]) break;
            n++;
            if (n > 60) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: ch %0d never ready", ch);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid[ch] = 1'b0;
        bus.in_last[ch]  = 1'b0;
    endtask

    // Both channels raise a single-byte FF frame together
    task automatic contend(input exp_t first, input exp_t second);
        int         n;
        logic [1:0] done;
        sb.push_back(first);
        sb.push_back(second);
        bus.in_data0 = 8'hFF;
        bus.in_data1 = 8'hFF;
        bus.in_last  = 2'b11;
        bus.in_valid = 2'b11;
        done = 2'b00;
        n = 0;
        while (done != 2'b11 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.in_ready[0] && bus.in_valid[0]) begin
                @(posedge clk);
                #1;
                bus.in_valid[0] = 1'b0;
                bus.in_last[0]  = 1'b0;
                done[0] = 1'b1;
            end else if (bus.in_ready[1] && bus.in_valid[1]) begin
                @(posedge clk);
                #1;
                bus.in_valid[1] = 1'b0;
                bus.in_last[1]  = 1'b0;
                done[1] = 1'b1;
            end
        end
        check("contend_done", 32'(done), 32'h3);
        clear_inputs();
    endtask

    task automatic seed(input logic ch, input logic [7:0] d);
        seed_wr   = 1'b1;
        seed_ch   = ch;
        seed_data = d;
        @(posedge clk);
        #1;
        seed_wr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'h0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, "_out_data"}, 32'(bus.out_data), 32'h0);
        check({tag, "_out_ch"}, 32'(bus.out_ch), 32'h0);
        check({tag, "_out_last"}, 32'(bus.out_last), 32'h0);
        check({tag, "_abort"}, 32'(abort), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int abort_at;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three-byte ch0 frame from the reset seed
        send(1'b0, 8'h00, 1'b0, 8'hCD);
        send(1'b0, 8'h00, 1'b0, 8'h9A);
        send(1'b0, 8'h00, 1'b1, 8'h35);
        gap();
        // Continuity: ch0 context resumes at 6A
        send(1'b0, 8'h00, 1'b1, 8'h6A);
        gap();
        // ch0 was last served, so ch1 wins this contention; ch0 then uses D4
        contend('{data: 8'h32, ch: 1'b1, last: 1'b1},
                '{data: 8'h2B, ch: 1'b0, last: 1'b1});
        gap();

        // Mid-frame reset
        send(1'b0, 8'h00, 1'b0, 8'hA8);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention straight after reset: ch0 first, both from seed CD
        contend('{data: 8'h32, ch: 1'b0, last: 1'b1},
                '{data: 8'h32, ch: 1'b1, last: 1'b1});
        gap();

        // Seed write in IDLE
        seed(1'b1, 8'h01);
        send(1'b1, 8'h00, 1'b0, 8'h01);
        send(1'b1, 8'h00, 1'b1, 8'h02);
        gap();
        send(1'b1, 8'h00, 1'b1, 8'h04);
        gap();

        // Seed write to the running channel: frame keeps old keystream
        send(1'b0, 8'h00, 1'b0, 8'h9A);
        seed(1'b0, 8'h55);
        send(1'b0, 8'h00, 1'b0, 8'h35);
        send(1'b0, 8'h00, 1'b1, 8'h6A);
        gap();
        send(1'b0, 8'h00, 1'b1, 8'h55);
        gap();

        // Idle inside a frame
        send(1'b0, 8'h00, 1'b0, 8'hAB);
        abort_at = -1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (abort && abort_at < 0) abort_at = i;
        end
`ifdef CIPHER_SCHED_TIMEOUT_EN
        check("abort_delay", 32'(abort_at), 32'd17);
        check("ready_after_abort", 32'(bus.in_ready), 32'h0);
`else
        check("no_abort", 32'(abort_at), 32'hFFFF_FFFF);
        check("still_running", 32'(bus.in_ready), 32'h1);
`endif
        @(posedge clk);
        #1;
        send(1'b0, 8'h00, 1'b1, 8'h57);
        gap();

`ifdef CIPHER_SCHED_TIMEOUT_EN
        check("abort_pulses", 32'(abort_seen), 32'd1);
`else
        check("abort_pulses", 32'(abort_seen), 32'd0);
`endif
        check("queue_empty", 32'(sb.size()), 32'd0);
        check("ready_onehot", 32'(ready_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
